chess_move_controller: RTL and testbench
========================================

Name: chess_move_controller

Overview:
- Owns the live 64-square board matrix and sequences every edit to it from the four direction keys plus a select key.
- Tracks a cursor, handles source/destination selection, commits moves, toggles the side to move and flags game end on king capture.
- Sits between the debounced key inputs and the board renderer. Its Turn output drives the chess timer block.
- Move legality (piece movement rules) is out of scope; only ownership checks are done here.

Parameters:
- CHESS_SQUARES, 64, number of board squares (8x8 fixed).
- SQUARE_WIDTH, 4, bits per square code.
- MATRIX_WIDTH, CHESS_SQUARES*SQUARE_WIDTH, flattened board width (256).

Ports:
- clock  input  1  system clock; all state is on its rising edge.
- resetApp  input  1  reset, asynchronous, active-high.
- KeyLeft  input  1  debounced level; rising edge moves cursor col-1.
- KeyRight  input  1  debounced level; rising edge moves cursor col+1.
- KeyUp  input  1  debounced level; rising edge moves cursor row+1.
- KeyDown  input  1  debounced level; rising edge moves cursor row-1.
- KeySelect  input  1  debounced level; rising edge selects or places.
- Matrix  output  MATRIX_WIDTH  board; square s = Matrix[4s+3:4s], s = row*8+col.
- CursorIdx  output  6  current cursor square.
- SrcIdx  output  6  latched source square; valid while SrcValid.
- SrcValid  output  1  high in SEL_DST.
- Turn  output  1  0 = white to move, 1 = black to move.
- MoveDone  output  1  one-cycle pulse on each commit.
- GameOver  output  1  sticky; set on king capture.

Behaviour:
- Square code:
  - bit3 = colour (0 white, 1 black).
  - bits2:0 = piece: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 reserved.
  - A square is empty when bits2:0 == 0.
- Reset (async) values:
  - Matrix = standard opening layout:
    - row0 = white R N B Q K B N R (col0..7).
    - row1 = white pawns.
    - rows 2..5 = 0.
    - row6 = black pawns.
    - row7 = black back rank.
  - CursorIdx = 12 (e2).
  - SrcIdx = 0, SrcValid = 0, Turn = 0, MoveDone = 0, GameOver = 0, state = SEL_SRC.
  - Key edge-detect registers reset to 0, so a key held through reset does not fire.
- Edge detect: each key is registered once. An event is current & ~previous, giving 1-cycle latency from input rise to action.
- Cursor movement:
  - Saturates at board edges; no wrap (col0 + Left stays at col0).
  - If several direction events occur in one cycle, apply only the highest priority: Left > Right > Up > Down.
  - Direction events are honoured in SEL_SRC and SEL_DST, and ignored in COMMIT and OVER.
  - A direction event and a select event in the same cycle: the select uses the pre-move CursorIdx, and the cursor moves in the same cycle.
- FSM states: SEL_SRC, SEL_DST, COMMIT, OVER.
- SEL_SRC, on select:
  - If the cursor square is non-empty and its colour == Turn: SrcIdx <= CursorIdx, SrcValid <= 1, go to SEL_DST.
  - Otherwise ignore.
- SEL_DST, on select:
  - Cursor == SrcIdx: cancel; SrcValid <= 0, go to SEL_SRC.
  - Cursor square holds a Turn-colour piece: re-select it; SrcIdx <= CursorIdx, stay in SEL_DST.
  - Otherwise (empty or opponent piece): latch DstIdx, go to COMMIT.
- COMMIT (exactly 1 cycle):
  - Matrix[Dst] <= Matrix[Src]; Matrix[Src] <= 0.
  - MoveDone = 1; SrcValid <= 0.
  - If the captured code had bits2:0 == 6: GameOver <= 1, go to OVER, Turn unchanged.
  - Else: Turn <= ~Turn, go to SEL_SRC.
- OVER: all keys ignored; Matrix frozen; left only by resetApp.
- Reset during any state (including COMMIT) aborts immediately; no partial write survives.
- No other path writes Matrix.

Decomposition:
- Shared package (chess_pkg):
  - piece codes EMPTY..KING, colour constants, SQUARE_WIDTH.
  - FSM state enum.
  - INIT_LAYOUT 256-bit constant, also used by the renderer.
- Sub-module key_edge_detect: per-key register plus rising-pulse output, instantiated 5 times.
- Cursor arithmetic and the FSM stay in the top module.

Test Plan:
- Reset -> Matrix == INIT_LAYOUT, CursorIdx = 12, Turn = 0, GameOver = 0. Then hold KeyLeft high across reset release -> no cursor move.
- From 12, Up x2, Select, Down x1?: sequence select at 12 (white pawn), Up, Up, Select -> COMMIT 1 cycle later: Matrix[28] = 0x1, Matrix[12] = 0, MoveDone pulse, Turn = 1.
- Turn = 0, cursor on 52 (black pawn), Select -> ignored, SrcValid stays 0. Cursor at 0, Left and Down pressed -> CursorIdx stays 0.
- Select on 12, Select again on 12 -> cancel, SrcValid = 0, Matrix unchanged. Select on 12, move to 11, Select -> SrcIdx = 11, still SEL_DST.
- Forced capture: white queen moved onto square holding black king (0xE) -> GameOver = 1, Turn stays 0, subsequent keys change nothing.
- Simultaneous Left+Right+Up from square 27 -> CursorIdx = 26 only. Assert resetApp mid-COMMIT -> Matrix == INIT_LAYOUT.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess encodings: square code fields, FSM states and the opening board.
package chess_pkg;

    localparam int unsigned CHESS_SQUARES = 64;
    localparam int unsigned SQUARE_WIDTH  = 4;
    localparam int unsigned MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH;
    localparam int unsigned IDX_WIDTH     = 6;

    typedef enum logic [2:0] {
        EMPTY    = 3'd0,
        PAWN     = 3'd1,
        KNIGHT   = 3'd2,
        BISHOP   = 3'd3,
        ROOK     = 3'd4,
        QUEEN    = 3'd5,
        KING     = 3'd6,
        RESERVED = 3'd7
    } piece_e;

    typedef enum logic {
        WHITE = 1'b0,
        BLACK = 1'b1
    } colour_e;

    typedef enum logic [1:0] {
        SEL_SRC = 2'd0,
        SEL_DST = 2'd1,
        COMMIT  = 2'd2,
        OVER    = 2'd3
    } state_e;

    // Rows packed high-to-low (row7 .. row0); within a row col7 is the top nibble.
    localparam logic [MATRIX_WIDTH-1:0] INIT_LAYOUT = {
        32'hCABE_DBAC,
        32'h9999_9999,
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000,
        32'h1111_1111,
        32'h4236_5324
    };

    function automatic logic [SQUARE_WIDTH-1:0] square_at(
        input logic [MATRIX_WIDTH-1:0] board,
        input logic [IDX_WIDTH-1:0]    idx
    );
        return board[{idx, 2'b00} +: SQUARE_WIDTH];
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge pulse for one debounced key; a key already held when reset lifts never fires.
module key_edge_detect (
    input  logic clock,
    input  logic resetApp,
    input  logic key_i,
    output logic pulse_c
);

    logic key_q;
    logic armed_q;

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            key_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            key_q   <= key_i;
            armed_q <= 1'b1;
        end
    end

    // armed_q masks the first post-reset cycle, before key_q has seen the level.
    assign pulse_c = armed_q & key_i & ~key_q;

endmodule

// File: rtl/chess_move_controller.sv
// Owns the board matrix: cursor navigation, source/destination selection and move commit.
module chess_move_controller
    import chess_pkg::*;
(
    input  logic                    clock,
    input  logic                    resetApp,
    input  logic                    KeyLeft,
    input  logic                    KeyRight,
    input  logic                    KeyUp,
    input  logic                    KeyDown,
    input  logic                    KeySelect,
    output logic [MATRIX_WIDTH-1:0] Matrix,
    output logic [IDX_WIDTH-1:0]    CursorIdx,
    output logic [IDX_WIDTH-1:0]    SrcIdx,
    output logic                    SrcValid,
    output logic                    Turn,
    output logic                    MoveDone,
    output logic                    GameOver
);

    localparam logic [IDX_WIDTH-1:0] CURSOR_RESET = IDX_WIDTH'(12);

    logic left_ev, right_ev, up_ev, down_ev, select_ev;

    key_edge_detect u_key_left   (.clock(clock), .resetApp(resetApp), .key_i(KeyLeft),   .pulse_c(left_ev));
    key_edge_detect u_key_right  (.clock(clock), .resetApp(resetApp), .key_i(KeyRight),  .pulse_c(right_ev));
    key_edge_detect u_key_up     (.clock(clock), .resetApp(resetApp), .key_i(KeyUp),     .pulse_c(up_ev));
    key_edge_detect u_key_down   (.clock(clock), .resetApp(resetApp), .key_i(KeyDown),   .pulse_c(down_ev));
    key_edge_detect u_key_select (.clock(clock), .resetApp(resetApp), .key_i(KeySelect), .pulse_c(select_ev));

    state_e                   state_q;
    logic [MATRIX_WIDTH-1:0]  matrix_q;
    logic [IDX_WIDTH-1:0]     cursor_q, cursor_d;
    logic [IDX_WIDTH-1:0]     src_q, dst_q;
    logic                     src_valid_q, turn_q, move_done_q, game_over_q;

    logic [SQUARE_WIDTH-1:0]  cur_sq, src_sq, dst_sq;
    logic                     cur_own;
    logic [2:0]               cur_row, cur_col;

    assign cur_sq  = square_at(matrix_q, cursor_q);
    assign src_sq  = square_at(matrix_q, src_q);
    assign dst_sq  = square_at(matrix_q, dst_q);
    assign cur_own = (cur_sq[2:0] != 3'(EMPTY)) && (cur_sq[3] == turn_q);
    assign cur_row = cursor_q[5:3];
    assign cur_col = cursor_q[2:0];

    // Saturating cursor step, one direction per cycle: Left > Right > Up > Down.
    always_comb begin
        cursor_d = cursor_q;
        if (state_q == SEL_SRC || state_q == SEL_DST) begin
            if (left_ev) begin
                if (cur_col != 3'd0) cursor_d = cursor_q - IDX_WIDTH'(1);
            end else if (right_ev) begin
                if (cur_col != 3'd7) cursor_d = cursor_q + IDX_WIDTH'(1);
            end else if (up_ev) begin
                if (cur_row != 3'd7) cursor_d = cursor_q + IDX_WIDTH'(8);
            end else if (down_ev) begin
                if (cur_row != 3'd0) cursor_d = cursor_q - IDX_WIDTH'(8);
            end
        end
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state_q     <= SEL_SRC;
            matrix_q    <= INIT_LAYOUT;
            cursor_q    <= CURSOR_RESET;
            src_q       <= '0;
            dst_q       <= '0;
            src_valid_q <= 1'b0;
            turn_q      <= 1'b0;
            move_done_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            move_done_q <= 1'b0;
            cursor_q    <= cursor_d;
            case (state_q)
                SEL_SRC: begin
                    if (select_ev && cur_own) begin
                        src_q       <= cursor_q;
                        src_valid_q <= 1'b1;
                        state_q     <= SEL_DST;
                    end
                end
                SEL_DST: begin
                    if (select_ev) begin
                        if (cursor_q == src_q) begin
                            src_valid_q <= 1'b0;
                            state_q     <= SEL_SRC;
                        end else if (cur_own) begin
                            src_q <= cursor_q;
                        end else begin
                            dst_q   <= cursor_q;
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    matrix_q[{dst_q, 2'b00} +: SQUARE_WIDTH] <= src_sq;
                    matrix_q[{src_q, 2'b00} +: SQUARE_WIDTH] <= '0;
                    move_done_q <= 1'b1;
                    src_valid_q <= 1'b0;
                    if (dst_sq[2:0] == 3'(KING)) begin
                        game_over_q <= 1'b1;
                        state_q     <= OVER;
                    end else begin
                        turn_q  <= ~turn_q;
                        state_q <= SEL_SRC;
                    end
                end
                OVER: begin
                    state_q <= OVER;
                end
                default: begin
                    state_q <= SEL_SRC;
                end
            endcase
        end
    end

    assign Matrix    = matrix_q;
    assign CursorIdx = cursor_q;
    assign SrcIdx    = src_q;
    assign SrcValid  = src_valid_q;
    assign Turn      = turn_q;
    assign MoveDone  = move_done_q;
    assign GameOver  = game_over_q;

endmodule

// File: tb/tb_chess_move_controller.sv
// Directed bench for chess_move_controller: navigation, selection, commit, capture and reset.
module tb_chess_move_controller;

    logic         clock = 1'b0;
    logic         resetApp;
    logic         KeyLeft, KeyRight, KeyUp, KeyDown, KeySelect;
    logic [255:0] Matrix;
    logic [5:0]   CursorIdx;
    logic [5:0]   SrcIdx;
    logic         SrcValid, Turn, MoveDone, GameOver;

    int n_vec = 0;
    int n_err = 0;

    logic [255:0] init_board;
    logic [255:0] exp_board;

    chess_move_controller dut (
        .clock    (clock),
        .resetApp (resetApp),
        .KeyLeft  (KeyLeft),
        .KeyRight (KeyRight),
        .KeyUp    (KeyUp),
        .KeyDown  (KeyDown),
        .KeySelect(KeySelect),
        .Matrix   (Matrix),
        .CursorIdx(CursorIdx),
        .SrcIdx   (SrcIdx),
        .SrcValid (SrcValid),
        .Turn     (Turn),
        .MoveDone (MoveDone),
        .GameOver (GameOver)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Keys go high on a falling edge, low one cycle later; outputs settle by the second falling edge.
    task automatic press(input logic l, input logic r, input logic u, input logic d, input logic s);
        KeyLeft = l; KeyRight = r; KeyUp = u; KeyDown = d; KeySelect = s;
        @(negedge clock);
        KeyLeft = 1'b0; KeyRight = 1'b0; KeyUp = 1'b0; KeyDown = 1'b0; KeySelect = 1'b0;
        @(negedge clock);
    endtask

    task automatic left();   press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic right();  press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic up();     press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic down();   press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic select(); press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

    initial begin
        init_board = {32'hCABEDBAC, 32'h99999999, 128'h0, 32'h11111111, 32'h42365324};
        KeyLeft = 1'b1; KeyRight = 1'b0; KeyUp = 1'b0; KeyDown = 1'b0; KeySelect = 1'b0;
        resetApp = 1'b1;

        // Reset state, with KeyLeft held across the release
        repeat (3) @(negedge clock);
        resetApp = 1'b0;
        repeat (3) @(negedge clock);
        KeyLeft = 1'b0;
        @(negedge clock);
        chk("reset_matrix", Matrix, init_board);
        chk("reset_cursor_held_left", 256'(CursorIdx), 256'd12);
        chk("reset_turn", 256'(Turn), 256'd0);
        chk("reset_gameover", 256'(GameOver), 256'd0);
        chk("reset_srcvalid", 256'(SrcValid), 256'd0);
        chk("reset_movedone", 256'(MoveDone), 256'd0);

        // Select on an opponent pawn (52) while white to move is ignored
        repeat (5) up();
        chk("cursor_up5", 256'(CursorIdx), 256'd52);
        select();
        chk("opp_select_ignored", 256'(SrcValid), 256'd0);

        // Saturation at square 0
        repeat (6) down();
        repeat (4) left();
        chk("cursor_to_0", 256'(CursorIdx), 256'd0);
        press(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("saturate_left_down", 256'(CursorIdx), 256'd0);

        // Select then cancel on the same square
        up();
        repeat (4) right();
        chk("cursor_back_12", 256'(CursorIdx), 256'd12);
        select();
        chk("src_select_valid", 256'(SrcValid), 256'd1);
        chk("src_select_idx", 256'(SrcIdx), 256'd12);
        select();
        chk("cancel_srcvalid", 256'(SrcValid), 256'd0);
        chk("cancel_matrix", Matrix, init_board);

        // Re-select to 11, back to 12, then commit e2-e4
        select();
        left();
        select();
        chk("reselect_idx11", 256'(SrcIdx), 256'd11);
        chk("reselect_valid", 256'(SrcValid), 256'd1);
        right();
        select();
        chk("reselect_idx12", 256'(SrcIdx), 256'd12);
        up();
        up();
        select();
        exp_board = init_board;
        exp_board[48 +: 4]  = 4'h0;
        exp_board[112 +: 4] = 4'h1;
        chk("commit_movedone", 256'(MoveDone), 256'd1);
        chk("commit_sq28", 256'(Matrix[112 +: 4]), 256'h1);
        chk("commit_sq12", 256'(Matrix[48 +: 4]), 256'h0);
        chk("commit_matrix", Matrix, exp_board);
        chk("commit_turn", 256'(Turn), 256'd1);
        chk("commit_srcvalid", 256'(SrcValid), 256'd0);
        @(negedge clock);
        chk("movedone_one_cycle", 256'(MoveDone), 256'd0);

        // Simultaneous Left+Right+Up from 27: only Left applies
        left();
        chk("cursor_27", 256'(CursorIdx), 256'd27);
        press(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("priority_left", 256'(CursorIdx), 256'd26);

        // Reset asserted while in COMMIT (black pawn 50 -> 42)
        repeat (3) up();
        select();
        chk("black_src_valid", 256'(SrcValid), 256'd1);
        down();
        KeySelect = 1'b1;
        @(posedge clock);
        #1;
        resetApp = 1'b1;
        KeySelect = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetApp = 1'b0;
        repeat (2) @(negedge clock);
        chk("midcommit_matrix", Matrix, init_board);
        chk("midcommit_turn", 256'(Turn), 256'd0);
        chk("midcommit_cursor", 256'(CursorIdx), 256'd12);
        chk("midcommit_srcvalid", 256'(SrcValid), 256'd0);

        // White queen (3) captures black king (60)
        down();
        left();
        select();
        chk("queen_src", 256'(SrcIdx), 256'd3);
        repeat (7) up();
        right();
        chk("cursor_60", 256'(CursorIdx), 256'd60);
        select();
        exp_board = init_board;
        exp_board[12 +: 4]  = 4'h0;
        exp_board[240 +: 4] = 4'h5;
        chk("king_capture_gameover", 256'(GameOver), 256'd1);
        chk("king_capture_turn", 256'(Turn), 256'd0);
        chk("king_capture_movedone", 256'(MoveDone), 256'd1);
        chk("king_capture_matrix", Matrix, exp_board);

        // OVER ignores all keys
        left();
        select();
        press(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        down();
        chk("over_cursor_frozen", 256'(CursorIdx), 256'd60);
        chk("over_matrix_frozen", Matrix, exp_board);
        chk("over_gameover_sticky", 256'(GameOver), 256'd1);
        chk("over_srcvalid", 256'(SrcValid), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
